// File: rtl/xalu_pkg.sv
// Shared types and constants for the HI/LO multiply-divide unit.
package xalu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MUL   = 3'd6
    } xalu_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } xalu_state_t;

    localparam int DIV_ITERS = 32;

endpackage

// File: rtl/xalu_div.sv
// Radix-2 restoring divider on unsigned magnitudes; done and the result are
// presented combinationally during the final iteration cycle.
module xalu_div
    import xalu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [5:0]  cnt;
    logic        run;
    logic [32:0] shifted;
    logic [32:0] diff;

    // One restoring step; the outputs are the post-step values.
    always_comb begin
        shifted   = {rem_q, quo_q[31]};
        diff      = shifted - {1'b0, dvs_q};
        remainder = diff[32] ? shifted[31:0] : diff[31:0];
        quotient  = {quo_q[30:0], ~diff[32]};
        done      = run && (cnt == 6'd1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt   <= '0;
            run   <= 1'b0;
        end else if (abort) begin
            cnt   <= '0;
            run   <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt   <= 6'(DIV_ITERS);
            run   <= 1'b1;
        end else if (run) begin
            rem_q <= remainder;
            quo_q <= quotient;
            if (cnt != 6'd0) cnt <= cnt - 6'd1;
            if (done) run <= 1'b0;
        end
    end

endmodule

// File: rtl/xalu.sv
// HI/LO execution unit: multi-cycle multiply, iterative divide, mthi/mtlo,
// with flush abort and a registered busy for the hazard unit.
module xalu
    import xalu_pkg::*;
#(
    parameter int MULT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  xalu_op_t    op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    xalu_state_t state, state_n;
    xalu_op_t    op_q;
    logic [31:0] a_q, b_q;
    logic [63:0] prod_q, prod;
    logic [5:0]  cnt;
    logic        setup;
    logic        accept, mul_sgn, is_div;
    logic        mul_fin, div_fin;
    logic        sa, sb, dz;
    logic [31:0] mag_a, mag_b, q_fix, r_fix;
    logic        div_done;
    logic [31:0] div_q, div_r;

    assign accept  = start && !flush && (state == IDLE);
    assign mul_sgn = (op == OP_MULT) || (op == OP_MUL);
    assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
    // Sign-extending to 64 bits makes one unsigned multiplier serve both forms.
    assign prod    = {{32{mul_sgn & src_a[31]}}, src_a} * {{32{mul_sgn & src_b[31]}}, src_b};

    assign sa    = (op_q == OP_DIV) && a_q[31];
    assign sb    = (op_q == OP_DIV) && b_q[31];
    assign dz    = (b_q == 32'd0);
    assign mag_a = sa ? 32'd0 - a_q : a_q;
    assign mag_b = sb ? 32'd0 - b_q : b_q;
    assign q_fix = (sa ^ sb) ? 32'd0 - div_q : div_q;
    assign r_fix = sa ? 32'd0 - div_r : div_r;

    assign mul_fin = (state == MUL_RUN) && (cnt == 6'd0) && !flush;
    assign div_fin = (state == DIV_RUN) && div_done && !flush;

    xalu_div u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (setup && !flush),
        .abort     (flush),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_div)
                        state_n = DIV_RUN;
                    else if (op == OP_MULT || op == OP_MULTU || op == OP_MUL)
                        state_n = MUL_RUN;
                end
            end
            MUL_RUN: if (flush || cnt == 6'd0) state_n = IDLE;
            DIV_RUN: if (flush || div_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            op_q   <= OP_MULT;
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            cnt    <= '0;
            setup  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            setup <= accept && is_div;
            if (accept) begin
                op_q   <= op;
                a_q    <= src_a;
                b_q    <= src_b;
                prod_q <= prod;
                cnt    <= 6'(MULT_CYCLES - 1);
                if (op == OP_MTHI) hi <= src_a;
                if (op == OP_MTLO) lo <= src_a;
            end else if (state == MUL_RUN && cnt != 6'd0) begin
                cnt <= cnt - 6'd1;
            end
            if (mul_fin) begin
                lo <= prod_q[31:0];
                if (op_q != OP_MUL) hi <= prod_q[63:32];
            end
            if (div_fin) begin
                lo <= dz ? 32'hFFFF_FFFF : q_fix;
                hi <= dz ? a_q : r_fix;
            end
        end
    end

endmodule

// File: tb/tb_xalu.sv
// Directed scoreboard bench for xalu: latency, results, flush and reset.
module tb_xalu;
    import xalu_pkg::*;

    localparam int MC = 3;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    xalu_op_t    op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        busy;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mhi = '0, mlo = '0;
    exp_t        sbq[$];

    xalu #(.MULT_CYCLES(MC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one issue cycle; the model result is queued only for ops meant to complete.
    task automatic issue(input xalu_op_t o, input logic [31:0] a, input logic [31:0] b, input bit keep);
        exp_t e;
        longint unsigned p;
        e.hi = mhi;
        e.lo = mlo;
        p = '0;
        case (o)
            OP_MULT, OP_MUL: p = longint'($signed(a)) * longint'($signed(b));
            OP_MULTU:        p = {32'd0, a} * {32'd0, b};
            default:         p = '0;
        endcase
        case (o)
            OP_MULT, OP_MULTU: begin e.hi = p[63:32]; e.lo = p[31:0]; end
            OP_MUL:  e.lo = p[31:0];
            OP_MTHI: e.hi = a;
            OP_MTLO: e.lo = a;
            OP_DIV: begin
                if (b == 32'd0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e.lo = a; e.hi = 32'd0; end
                else begin
                    e.lo = 32'($signed(a) / $signed(b));
                    e.hi = 32'($signed(a) % $signed(b));
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; end
                else begin e.lo = a / b; e.hi = a % b; end
            end
            default: ;
        endcase
        if (keep) begin
            mhi = e.hi;
            mlo = e.lo;
            sbq.push_back(e);
        end
        start = 1'b1; op = o; src_a = a; src_b = b;
        step();
        start = 1'b0; src_a = $urandom; src_b = $urandom;
    endtask

    // Count busy cycles (operands scrambled meanwhile), then pop and compare.
    task automatic wait_done(input string tag, input int nb);
        int   n;
        exp_t e;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
            src_a = $urandom; src_b = $urandom;
        end
        chk({tag, " busy_cycles"}, 32'(n), 32'(nb));
        checks++;
        assert (sbq.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard observed empty expected entry", tag);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({tag, " hi"}, hi, e.hi);
            chk({tag, " lo"}, lo, e.lo);
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; flush = 1'b0; op = OP_MULT; src_a = '0; src_b = '0;
        repeat (3) step();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        resetn = 1'b1;
        step();

        issue(OP_MTHI, 32'h1234_5678, 32'd0, 1'b1);
        wait_done("mthi", 0);
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b1);
        wait_done("mtlo", 0);

        issue(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
        wait_done("mult", MC);
        issue(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
        wait_done("multu", MC);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done("div -7/2", 33);
        issue(OP_DIVU, 32'd7, 32'd0, 1'b1);
        wait_done("divu 7/0", 33);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("div ovf", 33);
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_done("div 7/-2", 33);
        issue(OP_DIV, 32'hFFFF_FFF8, 32'd0, 1'b1);
        wait_done("div -8/0", 33);
        issue(OP_DIVU, 32'hFFFF_FFF0, 32'd10, 1'b1);
        wait_done("divu big", 33);

        issue(OP_MTHI, 32'hA5A5_A5A5, 32'd0, 1'b1);
        wait_done("mthi a5", 0);
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1);
        start = 1'b1; op = OP_MTHI; src_a = 32'hDEAD_BEEF;
        step();
        start = 1'b0;
        wait_done("mul ignore", MC - 1);

        // Flush in the tenth busy cycle of a divide.
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b0);
        repeat (9) step();
        chk("flush pre busy", 32'(busy), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush hi", hi, mhi);
        chk("flush lo", lo, mlo);
        issue(OP_MULTU, 32'h8000_0001, 32'h0000_0010, 1'b1);
        wait_done("multu post flush", MC);

        // Flush on the completing edge of a multiply.
        issue(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        repeat (MC - 1) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush last busy", 32'(busy), 32'd0);
        chk("flush last hi", hi, mhi);
        chk("flush last lo", lo, mlo);

        // Flush cancels a same-cycle start.
        start = 1'b1; op = OP_MTLO; src_a = 32'hCAFE_F00D; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        chk("flush start lo", lo, mlo);
        chk("flush start busy", 32'(busy), 32'd0);

        // Asynchronous reset in the twentieth busy cycle of a divide.
        issue(OP_DIV, 32'd1000, 32'd3, 1'b0);
        repeat (19) step();
        resetn = 1'b0;
        #1;
        mhi = '0; mlo = '0;
        chk("rst mid busy", 32'(busy), 32'd0);
        chk("rst mid hi", hi, 32'd0);
        chk("rst mid lo", lo, 32'd0);
        step();
        resetn = 1'b1;
        issue(OP_DIV, 32'd100, 32'd7, 1'b1);
        wait_done("div 100/7", 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
